mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/arb_starve_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_TIMEOUT      = 16;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive data grants that bypassed a waiting fetch.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port with a single
// outstanding transaction, starvation relief, flush kill and timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_funct3,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        err
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_t    state;
    logic          kill;
    logic [TW-1:0] tcnt;
    logic          at_limit;

    logic busy;
    logic done;
    logic timed_out;
    logic can_grant;
    logic i_cand;

    assign busy      = (state != IDLE);
    assign done      = busy && m_rvalid;
    assign timed_out = busy && !m_rvalid && (tcnt == TLAST);
    assign can_grant = !rst && (!busy || m_rvalid);
    assign i_cand    = i_req && !flush;

    // A flushed fetch is not a candidate, so data may still win at the limit.
    assign i_gnt = can_grant && i_cand && (!d_req || at_limit);
    assign d_gnt = can_grant && d_req && !(i_cand && at_limit);

    assign i_rvalid = !rst && m_rvalid && (state == BUSY_I) && !kill && !flush;
    assign d_rvalid = !rst && m_rvalid && (state == BUSY_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (d_gnt && i_req),
        .clr     (i_gnt || !i_req),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_funct3 <= '0;
            err      <= 1'b0;
            kill     <= 1'b0;
            tcnt     <= '0;
        end else begin
            m_req <= i_gnt || d_gnt;
            if (d_gnt) begin
                state    <= BUSY_D;
                m_we     <= d_we;
                m_addr   <= d_addr;
                m_wdata  <= d_wdata;
                m_funct3 <= d_funct3;
            end else if (i_gnt) begin
                state    <= BUSY_I;
                m_we     <= 1'b0;
                m_addr   <= i_addr;
                m_wdata  <= '0;
                m_funct3 <= FUNCT3_LW;
            end else if (done || timed_out) begin
                state <= IDLE;
            end

            if (timed_out) begin
                err <= 1'b1;
            end

            // Counts cycles since m_req; restarts on every new grant.
            if (busy && !done && !timed_out) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end

            kill <= (state == BUSY_I) && !done && !timed_out && (kill || flush);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference model of arbitration, kill and response routing.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_funct3;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .TIMEOUT     (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_funct3(d_funct3),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_funct3(m_funct3),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata),
        .err     (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Starvation sequence bookkeeping
    bit         prev_mreq;
    int         ng;
    logic [9:0] order;
    bit         both;
    bit         bad;

    // Reference model state: what is outstanding and when memory answers
    int          pend;        // 0 none, 1 fetch, 2 data
    bit          pend_killed;
    int          due;
    int          starve;
    bit          cmd_due;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [2:0]  e_f3;
    bit          completes;
    bit          free;
    bit          ig;
    bit          dg;
    bit          ei;
    bit          ed;

    initial begin
        rst = 1'b1; flush = 1'b0;
        i_req = 1'b1; i_addr = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
        m_rvalid = 1'b1; m_rdata = '0;

        // Reset values, with requests and a response present
        next_cycle();
        sample();
        check("rst_gnt", {i_gnt, d_gnt}, 2'b00);
        check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        check("rst_mcmd", {m_req, m_we, m_funct3, err}, 6'b0);
        check("rst_maddr", {m_addr, m_wdata}, 64'h0);

        // Single fetch with one-cycle memory
        next_cycle();
        rst = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        sample();
        check("f1_gnt", {i_gnt, d_gnt}, 2'b10);
        next_cycle();
        i_req = 1'b0;
        sample();
        check("f1_mreq", {m_req, m_we, m_funct3}, {1'b1, 1'b0, 3'd2});
        check("f1_maddr", {m_addr, m_wdata}, {32'h40, 32'h0});
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h0010_0093;
        sample();
        check("f1_rvalid", {i_rvalid, d_rvalid, m_req}, 3'b100);
        check("f1_rdata", i_rdata, 32'h0010_0093);

        // Simultaneous requests: data write first, fetch back-to-back
        next_cycle();
        m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'd2;
        sample();
        check("wr_gnt", {i_gnt, d_gnt}, 2'b01);
        next_cycle();
        d_req = 1'b0;
        sample();
        check("wr_mcmd", {m_req, m_we, m_funct3, i_gnt}, {1'b1, 1'b1, 3'd2, 1'b0});
        check("wr_maddr", {m_addr, m_wdata}, {32'h100, 32'hDEAD_BEEF});
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h1;
        sample();
        check("wr_done", {d_rvalid, i_rvalid, i_gnt, d_gnt}, 4'b1010);
        next_cycle();
        m_rvalid = 1'b0; i_req = 1'b0;
        sample();
        check("wr_fetch_cmd", {m_req, m_we, m_addr, m_wdata}, {1'b1, 1'b0, 32'h44, 32'h0});
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0013;
        sample();
        check("wr_fetch_rvalid", {i_rvalid, d_rvalid}, 2'b10);

        // Both ports held: fetch wins after LIMIT data grants
        next_cycle();
        m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h60;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        prev_mreq = 1'b0; ng = 0; order = '0; both = 1'b0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            m_rvalid = prev_mreq;
            sample();
            if (i_gnt && d_gnt) both = 1'b1;
            if (i_gnt) begin
                order[ng] = 1'b1;
                ng++;
            end else if (d_gnt) begin
                ng++;
            end
            prev_mreq = m_req;
            next_cycle();
        end
        check("starve_ngrants", ng, 10);
        check("starve_order", order, 10'b10_0001_0000);
        check("starve_exclusive", both, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_rvalid = prev_mreq;
            sample();
            prev_mreq = m_req;
            next_cycle();
        end

        // Flush kills an in-flight fetch; following fetch is unaffected
        m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h80;
        sample();
        check("kill_gnt", i_gnt, 1'b1);
        next_cycle();
        i_req = 1'b1; i_addr = 32'h84; flush = 1'b1;
        sample();
        check("kill_flush_blocks", {i_gnt, m_req, m_addr}, {1'b0, 1'b1, 32'h80});
        next_cycle();
        flush = 1'b0; i_addr = 32'h20;
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
        sample();
        check("kill_no_rvalid", {i_rvalid, i_gnt}, 2'b01);
        next_cycle();
        i_req = 1'b0; m_rvalid = 1'b0;
        sample();
        check("kill_next_cmd", {m_req, m_addr}, {1'b1, 32'h20});
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        sample();
        check("kill_next_rvalid", {i_rvalid, i_rdata}, {1'b1, 32'h1234_5678});

        // Timeout: memory never answers a read
        next_cycle();
        m_rvalid = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_funct3 = 3'd2;
        sample();
        check("tmo_gnt", d_gnt, 1'b1);
        next_cycle();
        d_req = 1'b0;
        sample();
        check("tmo_mreq", m_req, 1'b1);
        bad = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            next_cycle();
            sample();
            if (err || d_rvalid || i_rvalid || d_gnt) bad = 1'b1;
        end
        check("tmo_waiting", bad, 1'b0);
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h5555_AAAA;
        m_rvalid = 1'b1;
        sample();
        check("tmo_err_idle", {err, d_gnt, d_rvalid}, 3'b110);
        next_cycle();
        d_req = 1'b0; m_rvalid = 1'b0;
        sample();
        check("tmo_new_cmd", {m_req, m_addr}, {1'b1, 32'h300});
        next_cycle();
        rst = 1'b1;
        sample();
        next_cycle();
        rst = 1'b0;
        sample();
        check("tmo_rst_clears", {err, m_req}, 2'b00);

        // Reset in the middle of a data transaction
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D; d_funct3 = 3'd2;
        sample();
        check("mid_gnt", d_gnt, 1'b1);
        next_cycle();
        d_req = 1'b0;
        sample();
        check("mid_busy", {m_req, m_we}, 2'b11);
        next_cycle();
        rst = 1'b1; d_req = 1'b1; i_req = 1'b1;
        sample();
        check("mid_rst_gnt", {i_gnt, d_gnt, d_rvalid}, 3'b000);
        next_cycle();
        rst = 1'b0; d_req = 1'b0; i_req = 1'b0; m_rvalid = 1'b1;
        sample();
        check("mid_outputs", {m_req, m_we, m_funct3, err, d_rvalid, i_rvalid}, 8'b0);
        check("mid_maddr", {m_addr, m_wdata}, 64'h0);

        // Randomized traffic against the transaction-level model
        next_cycle();
        m_rvalid = 1'b0;
        pend = 0; pend_killed = 1'b0; due = 0; starve = 0; cmd_due = 1'b0;
        e_addr = '0; e_wdata = '0; e_we = 1'b0; e_f3 = '0;
        for (int c = 0; c < 400; c++) begin
            i_req    = ($urandom % 4) != 0;
            i_addr   = $urandom;
            d_req    = ($urandom % 2) != 0;
            d_we     = ($urandom % 2) != 0;
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_funct3 = 3'($urandom_range(0, 5));
            flush    = ($urandom % 7) == 0;
            m_rdata  = $urandom;
            m_rvalid = (pend != 0) ? (c == due) : (($urandom % 8) == 0);

            completes = (pend != 0) && m_rvalid;
            free      = (pend == 0) || completes;
            ig = free && i_req && !flush && (!d_req || starve == LIMIT);
            dg = free && d_req && !ig;
            ei = completes && (pend == 1) && !pend_killed && !flush;
            ed = completes && (pend == 2);

            sample();
            check("rnd_gnt", {i_gnt, d_gnt}, {ig, dg});
            check("rnd_rvalid", {i_rvalid, d_rvalid}, {ei, ed});
            if (ei) check("rnd_irdata", i_rdata, m_rdata);
            if (ed) check("rnd_drdata", d_rdata, m_rdata);
            check("rnd_mreq", {m_req, err}, {cmd_due, 1'b0});
            check("rnd_mcmd", {m_addr, m_wdata}, {e_addr, e_wdata});
            check("rnd_mctl", {m_we, m_funct3}, {e_we, e_f3});

            cmd_due = ig || dg;
            if (dg) begin
                e_addr = d_addr; e_wdata = d_wdata; e_we = d_we; e_f3 = d_funct3;
            end else if (ig) begin
                e_addr = i_addr; e_wdata = '0; e_we = 1'b0; e_f3 = 3'd2;
            end
            if (completes) pend = 0;
            else if (pend == 1 && flush) pend_killed = 1'b1;
            if (ig || dg) begin
                pend = ig ? 1 : 2;
                pend_killed = 1'b0;
                due = c + 1 + $urandom_range(1, 6);
            end
            if (ig || !i_req) starve = 0;
            else if (dg && starve < LIMIT) starve++;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
